psram_spi_responder: RTL and testbench
======================================

PSRAM_SPI_RESPONDER -- requirements
Module: psram_spi_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, meaning byte-address width of the internal array (2^MEM_AW bytes).
REQ-002 SHALL have port clk, input, 1, sole clock; no other clock is used.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port ce, input, 1, chip enable from the initiator, active-low, asynchronous to clk.
REQ-005 SHALL have port sclk, input, 1, serial clock, SPI mode 0, asynchronous to clk.
REQ-006 SHALL have port mosi, input, 1, serial data in, MSB first.
REQ-007 SHALL have port miso, output, 1, serial data out, MSB first.
REQ-008 SHALL have port miso_oe, output, 1, high only while read data is being driven.
REQ-009 SHALL have port busy, output, 1, high while a transaction is open (ce low after synchronisation).
REQ-010 SHALL have port last_cmd, output, 8, opcode of the most recent completed command byte.
REQ-011 SHALL have port cmd_err, output, 1, one-clk pulse on an unsupported opcode.

Function
REQ-012 SHALL pass ce, sclk and mosi through 2-flop synchronisers and use sclk edge detection in clk; sclk frequency SHALL be at most clk/8.
REQ-013 SHALL use states IDLE, CMD, ADDR, DUMMY, RD, WR, IGNORE.
REQ-014 SHALL move IDLE->CMD on a synchronised ce falling edge and clear the bit counter.
REQ-015 SHALL sample mosi on sclk rising edges; after 8 bits it SHALL latch last_cmd and decode the opcode.
REQ-016 SHALL decode 0x03 (read) and 0x02 (write) -> ADDR; any other opcode -> IGNORE with cmd_err pulsed one cycle.
REQ-017 SHALL collect 24 address bits in ADDR and keep only bits [MEM_AW-1:0]; upper bits are ignored.
REQ-018 SHALL, for reads, fetch the byte at the address and drive its MSB on miso at the sclk falling edge after the 32nd rising edge; subsequent bits SHALL change only on sclk falling edges.
REQ-019 SHALL, in RD, increment the address and prefetch the next byte after each 8 bits, wrapping from 2^MEM_AW-1 to 0.
REQ-020 SHALL, in WR, write each completed 8-bit byte to the array and increment the address with the same wrap rule.
REQ-021 SHALL hold miso_oe low except in RD (and its first-bit setup); miso SHALL be 0 when miso_oe is low.
REQ-022 SHALL, on a ce rising edge in any state, return to IDLE within 1 clk; a partial write byte SHALL be discarded and miso_oe SHALL drop.
REQ-023 SHALL, in IGNORE, discard all sclk activity until ce rises.
REQ-024 SHALL treat a ce falling edge coincident with a ce rising edge detection as the end of one transaction followed by the start of the next.

Reset
REQ-025 SHALL, on rst, set state IDLE, miso 0, miso_oe 0, busy 0, last_cmd 0x00, cmd_err 0, counters and synchronisers to idle values (ce=1, sclk=0).
REQ-026 SHALL NOT reset array contents; rst mid-transaction SHALL abort it without writing a partial byte.

Configuration
REQ-027 SHALL, with PSRAM_RESP_FASTREAD_EN defined, also decode 0x0B (fast read): ADDR -> DUMMY for 8 sclk cycles -> RD.
REQ-028 SHALL, without PSRAM_RESP_FASTREAD_EN, treat 0x0B as unsupported (IGNORE, cmd_err).

Structure
REQ-029 SHALL take opcode constants and the state encoding from shared package psram_pkg.
REQ-030 SHALL implement synchronisation and edge detection in one sub-module, psram_pin_sync (outputs: ce_s, ce_fall, ce_rise, sclk_rise, sclk_fall, mosi_s).

Verification
REQ-031 Write 0x02, addr 0x000010, data A5 5A -> array[0x010]=0xA5, array[0x011]=0x5A, last_cmd=0x02, miso_oe never high.
REQ-032 Read 0x03, addr 0x000010, 16 clocks -> miso shifts 0xA5 then 0x5A, miso_oe high only during data bits.
REQ-033 Write 3 bytes 11 22 33 at addr 0x000FFF (MEM_AW=12) -> array[0xFFF]=0x11, array[0x000]=0x22, array[0x001]=0x33.
REQ-034 Opcode 0x9F, then 40 clocks -> cmd_err one-cycle pulse, no array change, state IGNORE until ce high, then IDLE.
REQ-035 Write addr 0x20 with ce raised after 5 data bits -> array[0x20] unchanged; next read returns the old value.
REQ-036 With PSRAM_RESP_FASTREAD_EN: 0x0B, addr 0x10, 8 dummy clocks -> 0xA5 on miso; without the macro -> cmd_err pulse.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared opcodes and FSM state encoding for the PSRAM SPI responder.
package psram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RD,
        WR,
        IGNORE
    } state_t;

    localparam logic [7:0] OP_WRITE     = 8'h02;
    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

endpackage

// File: rtl/psram_pin_sync.sv
// Brings ce/sclk/mosi into the clk domain through 2-flop synchronisers and
// derives single-cycle edge strobes. Idle values: ce=1, sclk=0.
module psram_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic sclk,
    input  logic mosi,
    output logic ce_s,
    output logic ce_fall,
    output logic ce_rise,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_s
);
    logic [1:0] ce_q, sclk_q, mosi_q;
    logic       ce_d, sclk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_q   <= 2'b11;
            sclk_q <= 2'b00;
            mosi_q <= 2'b00;
            ce_d   <= 1'b1;
            sclk_d <= 1'b0;
        end else begin
            ce_q   <= {ce_q[0], ce};
            sclk_q <= {sclk_q[0], sclk};
            mosi_q <= {mosi_q[0], mosi};
            ce_d   <= ce_q[1];
            sclk_d <= sclk_q[1];
        end
    end

    assign ce_s      = ce_q[1];
    assign mosi_s    = mosi_q[1];
    assign ce_fall   = ce_d & ~ce_q[1];
    assign ce_rise   = ~ce_d & ce_q[1];
    assign sclk_rise = ~sclk_d & sclk_q[1];
    assign sclk_fall = sclk_d & ~sclk_q[1];

endmodule

// File: rtl/psram_spi_responder.sv
// SPI mode-0 PSRAM responder backed by a 2^MEM_AW byte array.
// Define PSRAM_RESP_FASTREAD_EN to also accept 0x0B (fast read, 8 dummy clocks).
module psram_spi_responder
    import psram_pkg::*;
#(
    parameter int MEM_AW = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       busy,
    output logic [7:0] last_cmd,
    output logic       cmd_err
);
    logic ce_s, ce_fall, ce_rise, sclk_rise, sclk_fall, mosi_s;

    psram_pin_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .sclk      (sclk),
        .mosi      (mosi),
        .ce_s      (ce_s),
        .ce_fall   (ce_fall),
        .ce_rise   (ce_rise),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi_s    (mosi_s)
    );

    state_t            state;
    logic [4:0]        bit_cnt;
    logic [7:0]        sh;
    logic [7:0]        tx_sh;
    logic [MEM_AW-1:0] addr;
    logic [7:0]        mem [2**MEM_AW];

    logic [7:0]        byte_in;
    logic [MEM_AW-1:0] addr_shift, addr_inc;
    logic              cmd_ok, mem_we;

    assign byte_in    = {sh[6:0], mosi_s};
    // Shifting through an MEM_AW-wide register drops the upper address bits.
    assign addr_shift = {addr[MEM_AW-2:0], mosi_s};
    assign addr_inc   = addr + 1'b1;
    assign mem_we     = (state == WR) && sclk_rise && (bit_cnt == 5'd7) && !ce_rise && !ce_fall;

    always_comb begin
        cmd_ok = (byte_in == OP_READ) || (byte_in == OP_WRITE);
`ifdef PSRAM_RESP_FASTREAD_EN
        if (byte_in == OP_FAST_READ) cmd_ok = 1'b1;
`endif
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= byte_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sh       <= '0;
            tx_sh    <= '0;
            addr     <= '0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            busy     <= 1'b0;
            last_cmd <= 8'h00;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            busy    <= ~ce_s;
            if (ce_rise) begin
                state   <= IDLE;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else if (ce_fall) begin
                state   <= CMD;
                bit_cnt <= '0;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    CMD: if (sclk_rise) begin
                        sh      <= byte_in;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            last_cmd <= byte_in;
                            bit_cnt  <= '0;
                            if (cmd_ok) state <= ADDR;
                            else begin
                                state   <= IGNORE;
                                cmd_err <= 1'b1;
                            end
                        end
                    end
                    ADDR: if (sclk_rise) begin
                        addr    <= addr_shift;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            if (last_cmd == OP_WRITE) state <= WR;
                            else if (last_cmd == OP_READ) begin
                                state <= RD;
                                tx_sh <= mem[addr_shift];
                            end else state <= DUMMY;
                        end
                    end
                    DUMMY: if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            state   <= RD;
                            tx_sh   <= mem[addr];
                        end
                    end
                    // Data changes only on sclk falls; the byte after the last bit is prefetched.
                    RD: if (sclk_fall) begin
                        miso    <= tx_sh[7];
                        miso_oe <= 1'b1;
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            addr    <= addr_inc;
                            tx_sh   <= mem[addr_inc];
                        end
                    end
                    WR: if (sclk_rise) begin
                        sh      <= byte_in;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            addr    <= addr_inc;
                        end
                    end
                    IDLE, IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_spi_responder.sv
// Self-checking bench: SPI master tasks, byte-array reference model, and a
// per-cycle monitor on miso/miso_oe/cmd_err.
module tb_psram_spi_responder;
    logic       clk = 1'b0;
    logic       rst, ce, sclk, mosi;
    logic       miso, miso_oe, busy, cmd_err;
    logic [7:0] last_cmd;

    always #5 clk = ~clk;

    psram_spi_responder #(.MEM_AW(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .busy     (busy),
        .last_cmd (last_cmd),
        .cmd_err  (cmd_err)
    );

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] model [4096];
    bit         known [4096];
    logic [7:0] wr_buf [8];
    logic [7:0] rd_buf [8];
    bit         oe_allowed = 1'b0;
    int         err_cycles = 0, err_pulses = 0;
    logic       err_prev = 1'b0;
    logic [7:0] rx_s;
    logic       oe_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle: miso quiet when not enabled, and enable only inside a read data phase.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (miso_oe !== 1'b1) chk("miso_zero_when_off", miso, 0);
            chk("oe_outside_read", {31'd0, miso_oe === 1'b1 && !oe_allowed}, 0);
            if (cmd_err === 1'b1) err_cycles++;
            if (cmd_err === 1'b1 && err_prev !== 1'b1) err_pulses++;
            err_prev = cmd_err;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start();
        ce = 1'b0;
        wclk(5);
        chk("busy_open", busy, 1);
    endtask

    task automatic spi_stop();
        sclk = 1'b0;
        wclk(5);
        ce = 1'b1;
        wclk(6);
        oe_allowed = 1'b0;
        wclk(4);
        chk("busy_closed", busy, 0);
        chk("oe_closed", miso_oe, 0);
    endtask

    // Mode 0: mosi set while sclk low, miso captured at the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx, output logic oe_all);
        rx = 8'h00;
        oe_all = 1'b1;
        for (int i = 0; i < nb; i++) begin
            mosi = tx[7-i];
            wclk(5);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            oe_all = oe_all & (miso_oe === 1'b1);
            wclk(5);
            sclk = 1'b0;
        end
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
        spi_bits(op, 8, rx_s, oe_s);
        spi_bits(a[23:16], 8, rx_s, oe_s);
        spi_bits(a[15:8], 8, rx_s, oe_s);
        spi_bits(a[7:0], 8, rx_s, oe_s);
    endtask

    task automatic do_write(input logic [23:0] a, input int n, input int part);
        spi_start();
        send_hdr(8'h02, a);
        for (int i = 0; i < n; i++) begin
            spi_bits(wr_buf[i], 8, rx_s, oe_s);
            model[(a[11:0] + i) % 4096] = wr_buf[i];
            known[(a[11:0] + i) % 4096] = 1'b1;
        end
        if (part > 0) spi_bits(8'($urandom), part, rx_s, oe_s);
        spi_stop();
        chk("last_cmd_write", last_cmd, 8'h02);
    endtask

    task automatic do_read(input logic [7:0] op, input logic [23:0] a, input int n);
        int idx;
        spi_start();
        send_hdr(op, a);
        if (op == 8'h0B) spi_bits(8'($urandom), 8, rx_s, oe_s);
        oe_allowed = 1'b1;
        for (int i = 0; i < n; i++) begin
            idx = (a[11:0] + i) % 4096;
            spi_bits(8'($urandom), 8, rx_s, oe_s);
            rd_buf[i] = rx_s;
            chk("read_oe_during_data", oe_s, 1);
            if (known[idx]) chk("read_data_vs_model", rx_s, model[idx]);
        end
        spi_stop();
        chk("last_cmd_read", last_cmd, op);
    endtask

    task automatic do_bad(input logic [7:0] op, input int nclk);
        int c0, p0;
        c0 = err_cycles;
        p0 = err_pulses;
        spi_start();
        spi_bits(op, 8, rx_s, oe_s);
        for (int i = 0; i < nclk; i++) spi_bits(8'($urandom), 1, rx_s, oe_s);
        chk("busy_in_ignore", busy, 1);
        spi_stop();
        chk("cmd_err_pulses", err_pulses - p0, 1);
        chk("cmd_err_width", err_cycles - c0, 1);
        chk("last_cmd_bad", last_cmd, op);
    endtask

    initial begin
        logic [23:0] a;
        logic [11:0] last_wr;
        int          n;
        rst = 1'b1; ce = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wclk(3);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last_cmd", last_cmd, 0);
        chk("rst_cmd_err", cmd_err, 0);
        rst = 1'b0;
        wclk(4);
        chk("post_rst_busy", busy, 0);

        wr_buf[0] = 8'hA5; wr_buf[1] = 8'h5A;
        do_write(24'h000010, 2, 0);
        do_read(8'h03, 24'h000010, 2);
        chk("lit_read_0x10", rd_buf[0], 8'hA5);
        chk("lit_read_0x11", rd_buf[1], 8'h5A);

        wr_buf[0] = 8'h11; wr_buf[1] = 8'h22; wr_buf[2] = 8'h33;
        do_write(24'h000FFF, 3, 0);
        do_read(8'h03, 24'h000FFF, 3);
        chk("lit_wrap_fff", rd_buf[0], 8'h11);
        chk("lit_wrap_000", rd_buf[1], 8'h22);
        chk("lit_wrap_001", rd_buf[2], 8'h33);

        do_bad(8'h9F, 40);
        do_read(8'h03, 24'h000010, 2);
        chk("lit_after_ignore", rd_buf[0], 8'hA5);

        wr_buf[0] = 8'hC3;
        do_write(24'h000020, 1, 0);
        wr_buf[0] = 8'hFF;
        do_write(24'h000020, 0, 5);
        do_read(8'h03, 24'h000020, 1);
        chk("lit_partial_discard", rd_buf[0], 8'hC3);

`ifdef PSRAM_RESP_FASTREAD_EN
        do_read(8'h0B, 24'h000010, 1);
        chk("lit_fast_read", rd_buf[0], 8'hA5);
`else
        do_bad(8'h0B, 16);
`endif

        // Reset in the middle of a write: no partial byte lands.
        wr_buf[0] = 8'h77;
        do_write(24'h000030, 1, 0);
        spi_start();
        send_hdr(8'h02, 24'h000030);
        spi_bits(8'h00, 4, rx_s, oe_s);
        rst = 1'b1;
        wclk(2);
        chk("midrst_last_cmd", last_cmd, 0);
        chk("midrst_busy", busy, 0);
        ce = 1'b1; sclk = 1'b0;
        rst = 1'b0;
        wclk(6);
        do_read(8'h03, 24'h000030, 1);
        chk("lit_midrst_keep", rd_buf[0], 8'h77);

        // Random traffic; upper address bits are noise the DUT must drop.
        last_wr = 12'h010;
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 5);
            if ($urandom_range(0, 1) == 0) begin
                a = {12'($urandom), 12'($urandom)};
                for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
                do_write(a, n, $urandom_range(0, 1) * $urandom_range(1, 7));
                last_wr = a[11:0];
            end else begin
                a = {12'($urandom), last_wr};
                do_read(8'h03, a, n);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
